// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh) feeding the seven-segment display stage.
// Optional lap-freeze feature is built only when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch #(
    parameter int unsigned TICK_DIVISOR = 1000000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        startStopPulse,
    input  logic        clearPulse,
    input  logic        lapPulse,
    output logic [15:0] data,
    output logic [3:0]  pointEnable,
    output logic        running,
    output logic        overflow
);

    localparam int unsigned PW = (TICK_DIVISOR > 2) ? $clog2(TICK_DIVISOR) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVISOR - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2
`ifdef STOPWATCH_LAP_EN
        ,
        StLap     = 2'd3
`endif
    } state_e;

    state_e         state_q;
    logic [15:0]    count_q;
    logic [PW-1:0]  presc_q;

    logic [15:0]    count_inc;
    logic           carry;
    logic           active;
    logic           tick;
    logic [PW-1:0]  presc_adv;
    logic [15:0]    count_adv;

`ifndef STOPWATCH_LAP_EN
    logic unused_lap;
    assign unused_lap = lapPulse;
`endif

    // Ripple BCD increment; carry out of the top digit marks the 99.99 wrap.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
`ifdef STOPWATCH_LAP_EN
        active = (state_q == StRunning) || (state_q == StLap);
`else
        active = (state_q == StRunning);
`endif
        tick      = active && (presc_q == PRESC_LAST);
        presc_adv = tick ? '0 : presc_q + PW'(1);
        count_adv = tick ? count_inc : count_q;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            count_q     <= '0;
            presc_q     <= '0;
            data        <= '0;
            pointEnable <= 4'b0000;
            running     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            pointEnable <= 4'b0100;
            if (clearPulse) begin
                state_q  <= StIdle;
                count_q  <= '0;
                presc_q  <= '0;
                data     <= '0;
                running  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (startStopPulse) begin
                            state_q <= StRunning;
                            running <= 1'b1;
                        end
                    end
                    StPaused: begin
                        if (startStopPulse) begin
                            state_q <= StRunning;
                            running <= 1'b1;
                        end
                    end
                    StRunning: begin
                        // Pausing holds the prescaler and drops a coincident tick.
                        if (startStopPulse) begin
                            state_q <= StPaused;
                            running <= 1'b0;
                            data    <= count_q;
                        end else begin
                            presc_q <= presc_adv;
                            count_q <= count_adv;
                            if (tick && carry) overflow <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                            if (lapPulse) begin
                                state_q <= StLap;
                                data    <= count_q;
                            end else begin
                                data <= count_adv;
                            end
`else
                            data <= count_adv;
`endif
                        end
                    end
`ifdef STOPWATCH_LAP_EN
                    StLap: begin
                        if (startStopPulse) begin
                            state_q <= StPaused;
                            running <= 1'b0;
                            data    <= count_q;
                        end else begin
                            presc_q <= presc_adv;
                            count_q <= count_adv;
                            if (tick && carry) overflow <= 1'b1;
                            if (lapPulse) begin
                                state_q <= StRunning;
                                data    <= count_adv;
                            end
                        end
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomised self-checking bench for bcd_stopwatch against an integer centisecond model.
// Lap-specific checks are enabled when STOPWATCH_LAP_EN is defined.
module tb_bcd_stopwatch;

    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        startStopPulse = 1'b0;
    logic        clearPulse = 1'b0;
    logic        lapPulse = 1'b0;
    logic [15:0] data;
    logic [3:0]  pointEnable;
    logic        running;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 idle, 1 running, 2 paused, 3 lap
    int m_mode = 0;
    int m_cs   = 0;
    int m_pre  = 0;
    int m_disp = 0;
    bit m_ovf  = 0;
    bit m_pe   = 0;

    bcd_stopwatch #(.TICK_DIVISOR(DIV)) dut (
        .clock          (clock),
        .resetN         (resetN),
        .startStopPulse (startStopPulse),
        .clearPulse     (clearPulse),
        .lapPulse       (lapPulse),
        .data           (data),
        .pointEnable    (pointEnable),
        .running        (running),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit lap_built();
`ifdef STOPWATCH_LAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cs = 0; m_pre = 0; m_disp = 0; m_ovf = 0; m_pe = 0;
    endtask

    task automatic model_step(input bit ss, input bit clr, input bit lap);
        int old;
        m_pe = 1;
        if (clr) begin
            m_mode = 0; m_cs = 0; m_pre = 0; m_disp = 0; m_ovf = 0;
        end else if (m_mode == 0 || m_mode == 2) begin
            if (ss) m_mode = 1;
            m_disp = m_cs;
        end else begin
            old = m_cs;
            if (ss) begin
                m_mode = 2;
            end else begin
                if (m_pre == DIV - 1) begin
                    m_pre = 0;
                    m_cs  = (m_cs + 1) % 10000;
                    if (m_cs == 0) m_ovf = 1;
                end else begin
                    m_pre++;
                end
                if (lap && lap_built()) begin
                    if (m_mode == 1) begin
                        m_mode = 3;
                        m_disp = old;
                    end else begin
                        m_mode = 1;
                    end
                end
            end
            if (m_mode != 3) m_disp = m_cs;
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".data"}, 32'(data), 32'(to_bcd(m_disp)));
        check({where, ".running"}, 32'(running), 32'(m_mode == 1 || m_mode == 3));
        check({where, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({where, ".pe"}, 32'(pointEnable), m_pe ? 32'h4 : 32'h0);
    endtask

    task automatic step(input bit ss, input bit clr, input bit lap, input string where);
        startStopPulse = ss;
        clearPulse     = clr;
        lapPulse       = lap;
        @(posedge clock);
        model_step(ss, clr, lap);
        #1;
        startStopPulse = 1'b0;
        clearPulse     = 1'b0;
        lapPulse       = 1'b0;
        compare_all(where);
    endtask

    task automatic idle_steps(input int n, input string where);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, where);
    endtask

    initial begin
        int budget;

        // Reset values without any clock edge yet
        #2;
        model_reset();
        compare_all("reset");
        #10;
        resetN = 1'b1;

        // Start and run ten ticks
        step(1'b1, 1'b0, 1'b0, "start");
        idle_steps(40, "run40");
        check("run40.const", 32'(data), 32'h0010);
        check("run40.pe", 32'(pointEnable), 32'h4);

        // Run up to 99.99 then wrap
        budget = 0;
        while (m_cs != 9999 && budget < 50000) begin
            step(1'b0, 1'b0, 1'b0, "to9999");
            budget++;
        end
        check("to9999.const", 32'(data), 32'h9999);
        budget = 0;
        while (m_cs != 0 && budget < 10) begin
            step(1'b0, 1'b0, 1'b0, "wrap");
            budget++;
        end
        check("wrap.data", 32'(data), 32'h0000);
        check("wrap.ovf", 32'(overflow), 32'h1);
        check("wrap.run", 32'(running), 32'h1);
        idle_steps(6, "postwrap");
        step(1'b0, 1'b1, 1'b0, "clear");
        check("clear.ovf", 32'(overflow), 32'h0);
        check("clear.run", 32'(running), 32'h0);

        // Pause mid-prescaler, hold, then resume
        step(1'b1, 1'b0, 1'b0, "start2");
        idle_steps(41, "run41");
        step(1'b1, 1'b0, 1'b0, "pause");
        idle_steps(100, "paused");
        check("paused.const", 32'(data), 32'h0010);
        step(1'b1, 1'b0, 1'b0, "resume");
        idle_steps(2, "resume.pre");
        check("resume.hold", 32'(data), 32'h0010);
        step(1'b0, 1'b0, 1'b0, "resume.tick");
        check("resume.inc", 32'(data), 32'h0011);

        // Pause pulse exactly on a tick edge: that tick is dropped
        budget = 0;
        while (m_pre != DIV - 1 && budget < 10) begin
            step(1'b0, 1'b0, 1'b0, "align");
            budget++;
        end
        step(1'b1, 1'b0, 1'b0, "pause.ontick");
        idle_steps(5, "paused2");

        // All three pulses together while running
        step(1'b1, 1'b0, 1'b0, "start3");
        idle_steps(9, "run9");
        step(1'b1, 1'b1, 1'b1, "triple");
        check("triple.data", 32'(data), 32'h0000);
        check("triple.run", 32'(running), 32'h0);
        idle_steps(5, "idle");

`ifdef STOPWATCH_LAP_EN
        step(1'b1, 1'b0, 1'b0, "start4");
        idle_steps(20, "run20");
        step(1'b0, 1'b0, 1'b1, "lap1");
        idle_steps(80, "lapped");
        check("lap.hold", 32'(data), 32'h0005);
        step(1'b0, 1'b0, 1'b1, "lap2");
        check("lap.live", 32'(data), 32'h0025);
        step(1'b0, 1'b0, 1'b1, "lap3");
        idle_steps(7, "lapped2");
        step(1'b1, 1'b0, 1'b0, "lap.pause");
        idle_steps(5, "lap.paused");
        step(1'b0, 1'b1, 1'b0, "clear4");
`else
        step(1'b1, 1'b0, 1'b0, "start4");
        idle_steps(20, "run20");
        step(1'b0, 1'b0, 1'b1, "lap.ignored");
        idle_steps(10, "nolap");
        check("nolap.live", 32'(data), 32'h0007);
        step(1'b0, 1'b1, 1'b0, "clear4");
`endif

        // Random pulse stream
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 399) == 0,
                 $urandom_range(0, 24) == 0, "rand");
        end

        // Async reset mid-count at 00.37
        step(1'b0, 1'b1, 1'b0, "clear5");
        step(1'b1, 1'b0, 1'b0, "start5");
        idle_steps(37 * DIV + 1, "run37");
        check("run37.const", 32'(data), 32'h0037);
        #1;
        resetN = 1'b0;
        #1;
        model_reset();
        compare_all("async");
        check("async.data", 32'(data), 32'h0000);
        check("async.pe", 32'(pointEnable), 32'h0);
        #1;
        resetN = 1'b1;
        idle_steps(3, "release");
        check("release.data", 32'(data), 32'h0000);
        check("release.run", 32'(running), 32'h0);
        step(1'b1, 1'b0, 1'b0, "restart");
        idle_steps(DIV, "restart.tick");
        check("restart.inc", 32'(data), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Four-digit BCD stopwatch that produces the `data` and `pointEnable` words consumed by the `SevenSegmentController` display stage. It sits between the debounced button edge detectors and the display controller. It turns single-cycle start/stop, clear and lap pulses into a running SS.hh count: seconds 00–99, hundredths 00–99. All outputs are registered so the display stage sees glitch-free values.

## Interface
- `TICK_DIVISOR`, default 1000000: clock cycles per hundredth-second tick; must be ≥2.
- `clock`  input  1  rising-edge system clock.
- `resetN`  input  1  asynchronous, active-low reset.
- `startStopPulse`  input  1  one-cycle pulse; toggles counting.
- `clearPulse`  input  1  one-cycle pulse; zeroes count and returns to IDLE.
- `lapPulse`  input  1  one-cycle pulse; freezes/unfreezes displayed value (only with `STOPWATCH_LAP_EN`).
- `data`  output  16  displayed BCD digits: [15:12] tens of seconds, [11:8] seconds, [7:4] tenths, [3:0] hundredths.
- `pointEnable`  output  4  decimal-point mask; constant 4'b0100 outside reset.
- `running`  output  1  high in RUNNING or LAP.
- `overflow`  output  1  sticky; set when the count wraps 99.99 → 00.00.

## Operation
- Reset (`resetN` low, asynchronous): state IDLE, count 0000, prescaler 0, `data`=16'h0000, `pointEnable`=4'b0000, `running`=0, `overflow`=0.
- Internal count: four BCD digits. Each digit wraps 9→0 with carry into the next. The top digit wraps 9→0 with no further carry; this wrap sets `overflow`.
- Prescaler: counts 0..TICK_DIVISOR-1 while RUNNING or LAP. At terminal value it reloads 0 and issues a tick, which increments the count. It holds in PAUSED and is zeroed in IDLE.
- States:
  - IDLE: count is zero. `startStopPulse` → RUNNING.
  - RUNNING: `startStopPulse` → PAUSED. `lapPulse` → LAP.
  - PAUSED: `startStopPulse` → RUNNING. The prescaler resumes from its held value.
  - LAP: counting continues while `data` holds its captured value. `lapPulse` → RUNNING. `startStopPulse` → PAUSED, and `data` shows the live count again.
  - `clearPulse` from any state → IDLE. Count, prescaler and `overflow` are zeroed.
- Simultaneous pulses: clear has priority over start/stop, which has priority over lap. Lower-priority pulses in the same cycle are dropped.
- `data` equals the live count in every state except LAP. On entry to LAP it is captured from the count value before that cycle's tick.
- `overflow` is cleared only by `clearPulse` or reset.

## Timing
- All outputs are registered. `data` reflects a tick one cycle after the edge at which the prescaler hits its terminal value.
- Start from IDLE on edge N: `running`=1 after edge N. The first increment lands on edge N+TICK_DIVISOR and is visible on `data` after that edge.
- Pause, resume and clear take effect on the edge that samples the pulse. A tick coincident with a pause pulse is discarded.
- Reset assertion mid-count forces all outputs to reset values immediately, without waiting for a clock edge. Deassertion is synchronised by the upstream reset debouncer.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - LAP state and capture register are built.
  - `lapPulse` behaves as described above.
- Undefined:
  - LAP state and capture register are omitted.
  - `lapPulse` is ignored.
  - `data` always equals the live count.

## Test plan
- TICK_DIVISOR=4. Reset, start pulse, wait 40 cycles → `data`=16'h0010, `running`=1, `pointEnable`=4'b0100.
- Preload by running to 99.99 (1 tick before wrap), one more tick → `data`=16'h0000, `overflow`=1, `running`=1. Clear pulse → `overflow`=0, IDLE.
- Start, 10 ticks, pause pulse, wait 100 cycles → `data` stays 16'h0010. Resume → next increment 16'h0011 after the remaining prescaler cycles.
- Assert start, clear and lap in the same cycle while RUNNING → IDLE, `data`=16'h0000, `running`=0.
- With `STOPWATCH_LAP_EN`: lap at 00.05, run 20 more ticks → `data` holds 16'h0005. Second lap → `data`=16'h0025.
- Drop `resetN` mid-count at 00.37 without a clock edge → `data`=16'h0000 and `pointEnable`=4'b0000 immediately. Release → IDLE.
